// File: rtl/scatter_arb_pkg.sv
// Shared definitions for the DMA scatter-path arbiters.
//   - Default DMA field widths.
//   - Header field offsets. The header layout is {addr, aux_len, byte_len},
//     with byte_len in the LSBs.
//   - The FSM state type.
//   - calc_beats: converts a byte length into a data-beat count.
package scatter_arb_pkg;

    localparam int DMA_LENGTH_WIDTH = 32;
    localparam int DMA_ADDR_WIDTH   = 64;
    localparam int DMA_DATA_WIDTH   = 256;

    localparam int BYTE_LEN_LSB = 0;
    localparam int AUX_LEN_LSB  = DMA_LENGTH_WIDTH;
    localparam int ADDR_LSB     = 2 * DMA_LENGTH_WIDTH;

    localparam int unsigned BEAT_BYTES_LOG = $clog2(DMA_DATA_WIDTH / 8);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    // ceil(byte_len / 2**beat_log).
    // Computed as a shift, plus a carry when any of the dropped low bits are set.
    // The shift never overflows, so 0xFFFF_FFFF on a 32-byte beat yields
    // 0x0800_0000.
    function automatic logic [63:0] calc_beats(input logic [63:0] byte_len,
                                               input int unsigned beat_log = BEAT_BYTES_LOG);
        logic [63:0] low_mask;
        low_mask = (64'd1 << beat_log) - 64'd1;
        return (byte_len >> beat_log) + {63'd0, |(byte_len & low_mask)};
    endfunction

endpackage

// File: rtl/scatter_rr_picker.sv
// Combinational round-robin picker, usable by any of the shared-DMA arbiters.
//   req      : request vector, one bit per requester
//   ptr      : index with the highest priority; the search wraps modulo NUM_REQ
//   gnt_idx  : index of the winning requester (0 when gnt_vld is low)
//   gnt_vld  : at least one request is set
// ptr must be below NUM_REQ.
module scatter_rr_picker #(
    parameter int NUM_REQ   = 2,
    parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 gnt_vld
);

    int cand;

    // Walk the offsets from farthest to nearest, so the request closest to ptr
    // is the last one assigned and therefore wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand]) begin
                gnt_idx = IDX_WIDTH'(cand);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scatter_arbiter.sv
// Shares the DMA scatter path (request FIFO plus data FIFO) among NUM_REQ
// receive-side producers. A granted producer keeps the path until its header
// and every data beat implied by the header's byte_len have been written.
//
// Ports:
//   clk, rst                 : clock; asynchronous active-low reset
//   in_req_valid/_head/_ready: per-producer header handshake; the header is
//                              {addr, aux_len, byte_len}
//   in_data_valid/in_data/in_data_ready : per-producer data beat handshake
//   scatter_req_wen/_din     : registered write port of the request FIFO
//   scatter_req_prog_full    : the request FIFO cannot take another header
//   scatter_data_wen/_din    : registered write port of the data FIFO
//   scatter_data_prog_full   : the data FIFO cannot take another beat
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | arbitrate headers; no data beat is accepted
// DATA  | forward beats from grant_idx until beats_left reaches 0
module scatter_arbiter
    import scatter_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int LEN_WIDTH  = DMA_LENGTH_WIDTH,
    parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMA_DATA_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        in_req_valid,
    input  logic [NUM_REQ*(2*LEN_WIDTH+ADDR_WIDTH)-1:0] in_req_head,
    output logic [NUM_REQ-1:0]                        in_req_ready,
    input  logic [NUM_REQ-1:0]                        in_data_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]             in_data,
    output logic [NUM_REQ-1:0]                        in_data_ready,
    output logic                                      scatter_req_wen,
    output logic [2*LEN_WIDTH+ADDR_WIDTH-1:0]         scatter_req_din,
    input  logic                                      scatter_req_prog_full,
    output logic                                      scatter_data_wen,
    output logic [DATA_WIDTH-1:0]                     scatter_data_din,
    input  logic                                      scatter_data_prog_full
);

    localparam int          HEAD_WIDTH = 2 * LEN_WIDTH + ADDR_WIDTH;
    localparam int          IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_LOG   = $clog2(DATA_WIDTH / 8);

    state_t                 state, state_nxt;
    logic [IDX_WIDTH-1:0]   grant_idx, grant_idx_nxt;
    logic [IDX_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic [LEN_WIDTH-1:0]   beats_left, beats_left_nxt;

    logic [IDX_WIDTH-1:0]   pick_idx;
    logic                   pick_vld;
    logic [HEAD_WIDTH-1:0]  pick_head;
    logic [LEN_WIDTH-1:0]   head_beats;
    logic [DATA_WIDTH-1:0]  grant_data;
    logic                   req_accept;
    logic                   data_open;
    logic                   data_accept;

    scatter_rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req     (in_req_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign pick_head  = in_req_head[pick_idx*HEAD_WIDTH +: HEAD_WIDTH];
    assign head_beats = LEN_WIDTH'(calc_beats(64'(pick_head[BYTE_LEN_LSB +: LEN_WIDTH]), BEAT_LOG));
    assign grant_data = in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // prog_full is sampled in the acceptance cycle. The FIFOs must therefore
    // leave slack for the write that lands one cycle later.
    assign req_accept  = (state == IDLE) && pick_vld && !scatter_req_prog_full;
    assign data_open   = (state == DATA) && !scatter_data_prog_full;
    assign data_accept = data_open && in_data_valid[grant_idx];

    always_comb begin
        in_req_ready  = '0;
        in_data_ready = '0;
        if (req_accept) begin
            in_req_ready[pick_idx] = 1'b1;
        end
        if (data_open) begin
            in_data_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_idx_nxt  = grant_idx;
        rr_ptr_nxt     = rr_ptr;
        beats_left_nxt = beats_left;
        case (state)
            IDLE: begin
                if (req_accept) begin
                    grant_idx_nxt = pick_idx;
                    rr_ptr_nxt    = (pick_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    // A zero-length header is header-only, so the FSM stays in IDLE.
                    if (head_beats != '0) begin
                        beats_left_nxt = head_beats;
                        state_nxt      = DATA;
                    end
                end
            end
            DATA: begin
                if (data_accept) begin
                    beats_left_nxt = beats_left - 1'b1;
                    if (beats_left == LEN_WIDTH'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            grant_idx        <= '0;
            rr_ptr           <= '0;
            beats_left       <= '0;
            scatter_req_wen  <= 1'b0;
            scatter_req_din  <= '0;
            scatter_data_wen <= 1'b0;
            scatter_data_din <= '0;
        end else begin
            state            <= state_nxt;
            grant_idx        <= grant_idx_nxt;
            rr_ptr           <= rr_ptr_nxt;
            beats_left       <= beats_left_nxt;
            scatter_req_wen  <= req_accept;
            scatter_data_wen <= data_accept;
            if (req_accept) begin
                scatter_req_din <= pick_head;
            end
            if (data_accept) begin
                scatter_data_din <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_scatter_arbiter.sv
module tb_scatter_arbiter;
    import scatter_arb_pkg::*;

    localparam int HW = 128;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    in_req_valid;
    logic [2*HW-1:0] in_req_head;
    logic [1:0]    in_req_ready;
    logic [1:0]    in_data_valid;
    logic [2*DW-1:0] in_data;
    logic [1:0]    in_data_ready;
    logic          scatter_req_wen;
    logic [HW-1:0] scatter_req_din;
    logic          scatter_req_prog_full;
    logic          scatter_data_wen;
    logic [DW-1:0] scatter_data_din;
    logic          scatter_data_prog_full;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    scatter_arbiter dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_req_valid           (in_req_valid),
        .in_req_head            (in_req_head),
        .in_req_ready           (in_req_ready),
        .in_data_valid          (in_data_valid),
        .in_data                (in_data),
        .in_data_ready          (in_data_ready),
        .scatter_req_wen        (scatter_req_wen),
        .scatter_req_din        (scatter_req_din),
        .scatter_req_prog_full  (scatter_req_prog_full),
        .scatter_data_wen       (scatter_data_wen),
        .scatter_data_din       (scatter_data_din),
        .scatter_data_prog_full (scatter_data_prog_full)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [HW-1:0] mk_hdr(input int p, input logic [31:0] blen, input logic [63:0] addr);
        return {addr, 32'hA0A0_0000 | 32'(p), blen};
    endfunction

    function automatic logic [DW-1:0] beat(input int p, input int i);
        return {8'(p), 216'hCAFE_F00D_1234_5678, 32'(i)};
    endfunction

    // Header, optional request-FIFO stall, then nbeats data beats, with an
    // optional data-FIFO stall of stall_len cycles before beat stall_at.
    task automatic run_burst(input int p, input logic [31:0] blen, input logic [63:0] addr,
                             input int nbeats, input int req_stall, input int stall_at,
                             input int stall_len);
        logic [HW-1:0] hdr;
        logic [DW-1:0] last;
        bit prev_acc;
        bit first;
        bit stalling;
        int i;
        int stalls;
        hdr = mk_hdr(p, blen, addr);
        for (int s = 0; s < req_stall; s++) begin
            @(negedge clk);
            in_req_head[p*HW +: HW] = hdr;
            in_req_valid[p] = 1'b1;
            scatter_req_prog_full = 1'b1;
            #1;
            chk("req_blocked", in_req_ready, 0);
            chk("req_wen_blocked", scatter_req_wen, 0);
        end
        @(negedge clk);
        scatter_req_prog_full = 1'b0;
        in_req_head[p*HW +: HW] = hdr;
        in_req_valid[p] = 1'b1;
        #1;
        chk("req_ready", in_req_ready, 1 << p);
        chk("data_ready_idle", in_data_ready, 0);
        prev_acc = 0;
        first = 1;
        i = 0;
        stalls = 0;
        last = '0;
        while (i < nbeats) begin
            @(negedge clk);
            in_req_valid[p] = 1'b0;
            stalling = (i == stall_at) && (stalls < stall_len);
            scatter_data_prog_full = stalling;
            in_data_valid[p] = 1'b1;
            in_data[p*DW +: DW] = beat(p, i);
            #1;
            chk("req_wen", scatter_req_wen, first);
            if (first) chk("req_din", scatter_req_din, hdr);
            chk("data_ready", in_data_ready, stalling ? 0 : (1 << p));
            chk("data_wen", scatter_data_wen, prev_acc);
            if (prev_acc) chk("data_din", scatter_data_din, last);
            first = 0;
            if (stalling) begin
                stalls++;
                prev_acc = 0;
            end else begin
                prev_acc = 1;
                last = beat(p, i);
                i++;
            end
        end
        @(negedge clk);
        in_req_valid[p] = 1'b0;
        in_data_valid[p] = 1'b0;
        scatter_data_prog_full = 1'b0;
        #1;
        chk("req_wen_tail", scatter_req_wen, first);
        if (first) chk("req_din_tail", scatter_req_din, hdr);
        chk("data_ready_tail", in_data_ready, 0);
        chk("data_wen_tail", scatter_data_wen, prev_acc);
        if (prev_acc) chk("data_din_tail", scatter_data_din, last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [HW-1:0] h0, h1;
        int e, pe;
        rst = 1'b0;
        in_req_valid = '0;
        in_req_head = '0;
        in_data_valid = '0;
        in_data = '0;
        scatter_req_prog_full = 1'b0;
        scatter_data_prog_full = 1'b0;
        #1;
        chk("rst_req_wen", scatter_req_wen, 0);
        chk("rst_data_wen", scatter_data_wen, 0);
        chk("rst_req_din", scatter_req_din, 0);
        chk("rst_data_din", scatter_data_din, 0);
        chk("rst_state", dut.state, IDLE);
        chk("rst_rr_ptr", dut.rr_ptr, 0);
        chk("rst_beats_left", dut.beats_left, 0);
        chk("rst_grant_idx", dut.grant_idx, 0);
        @(negedge clk);
        rst = 1'b1;

        // Fairness: both producers hold 32-byte headers, so grants go 0,1,0,1.
        h0 = mk_hdr(0, 32, 64'h1000);
        h1 = mk_hdr(1, 32, 64'h2000);
        pe = 0;
        for (int k = 0; k < 4; k++) begin
            e = k % 2;
            @(negedge clk);
            if (k == 0) begin
                in_req_head = {h1, h0};
                in_req_valid = 2'b11;
                in_data = {beat(1, 0), beat(0, 0)};
                in_data_valid = 2'b11;
            end
            #1;
            chk("fair_req_ready", in_req_ready, 1 << e);
            chk("fair_data_ready_idle", in_data_ready, 0);
            if (k > 0) begin
                chk("fair_data_wen", scatter_data_wen, 1);
                chk("fair_data_din", scatter_data_din, beat(pe, 0));
            end
            @(negedge clk);
            #1;
            chk("fair_req_ready_data", in_req_ready, 0);
            chk("fair_data_ready", in_data_ready, 1 << e);
            chk("fair_req_wen", scatter_req_wen, 1);
            chk("fair_req_din", scatter_req_din, (e == 0) ? h0 : h1);
            pe = e;
        end
        @(negedge clk);
        in_req_valid = '0;
        in_data_valid = '0;
        #1;
        chk("fair_last_wen", scatter_data_wen, 1);
        chk("fair_last_din", scatter_data_din, beat(1, 0));

        // Single burst: 100 bytes -> 4 beats.
        run_burst(0, 100, 64'hDEAD_0000, 4, 0, -1, 0);

        // Zero length from producer 1; producer 0 is accepted the very next cycle.
        h1 = mk_hdr(1, 0, 64'h3000);
        h0 = mk_hdr(0, 32, 64'h4000);
        @(negedge clk);
        in_req_head = {h1, h0};
        in_req_valid = 2'b11;
        #1;
        chk("zl_ready_p1", in_req_ready, 2'b10);
        @(negedge clk);
        in_req_valid[1] = 1'b0;
        #1;
        chk("zl_ready_p0", in_req_ready, 2'b01);
        chk("zl_req_wen", scatter_req_wen, 1);
        chk("zl_req_din", scatter_req_din, h1);
        chk("zl_data_wen", scatter_data_wen, 0);
        @(negedge clk);
        in_req_valid[0] = 1'b0;
        in_data_valid[0] = 1'b1;
        in_data[0 +: DW] = beat(0, 7);
        #1;
        chk("zl_req_wen2", scatter_req_wen, 1);
        chk("zl_req_din2", scatter_req_din, h0);
        chk("zl_data_ready", in_data_ready, 2'b01);
        chk("zl_data_wen2", scatter_data_wen, 0);
        @(negedge clk);
        in_data_valid = '0;
        #1;
        chk("zl_data_wen3", scatter_data_wen, 1);
        chk("zl_data_din3", scatter_data_din, beat(0, 7));
        chk("zl_req_wen3", scatter_req_wen, 0);

        // Data-FIFO backpressure for 5 cycles before beat 2.
        run_burst(1, 128, 64'h5000, 4, 0, 2, 5);
        // Request-FIFO backpressure; 33 bytes -> 2 beats.
        run_burst(0, 33, 64'h6000, 2, 3, -1, 0);
        // 32 bytes -> 1 beat.
        run_burst(1, 32, 64'h7000, 1, 0, -1, 0);
        // Header only.
        run_burst(0, 0, 64'h8000, 0, 0, -1, 0);

        // Reset after beat 2 of 4; rr_ptr is 1 going in.
        @(negedge clk);
        in_req_head[HW +: HW] = mk_hdr(1, 128, 64'h9000);
        in_req_valid = 2'b10;
        #1;
        chk("rm_ready", in_req_ready, 2'b10);
        @(negedge clk);
        in_req_valid = '0;
        in_data_valid = 2'b10;
        in_data[DW +: DW] = beat(1, 0);
        #1;
        chk("rm_data_ready", in_data_ready, 2'b10);
        @(negedge clk);
        in_data[DW +: DW] = beat(1, 1);
        #1;
        chk("rm_data_wen", scatter_data_wen, 1);
        @(negedge clk);
        in_data_valid = '0;
        #1;
        rst = 1'b0;
        #1;
        chk("rm_req_wen", scatter_req_wen, 0);
        chk("rm_data_wen_rst", scatter_data_wen, 0);
        chk("rm_req_din", scatter_req_din, 0);
        chk("rm_data_din", scatter_data_din, 0);
        chk("rm_state", dut.state, IDLE);
        chk("rm_rr_ptr", dut.rr_ptr, 0);
        chk("rm_beats_left", dut.beats_left, 0);
        chk("rm_data_ready_rst", in_data_ready, 0);
        h0 = mk_hdr(0, 0, 64'hA000);
        h1 = mk_hdr(1, 0, 64'hB000);
        @(negedge clk);
        rst = 1'b1;
        in_req_head = {h1, h0};
        in_req_valid = 2'b11;
        #1;
        chk("rm_first_win", in_req_ready, 2'b01);
        @(negedge clk);
        in_req_valid[0] = 1'b0;
        #1;
        chk("rm_second_win", in_req_ready, 2'b10);
        chk("rm_req_din0", scatter_req_din, h0);
        @(negedge clk);
        in_req_valid = '0;
        #1;
        chk("rm_req_din1", scatter_req_din, h1);

        // Maximum byte_len rounding.
        @(negedge clk);
        in_req_head[0 +: HW] = mk_hdr(0, 32'hFFFF_FFFF, 64'hC000);
        in_req_valid = 2'b01;
        #1;
        chk("max_ready", in_req_ready, 2'b01);
        @(negedge clk);
        in_req_valid = '0;
        in_data_valid = 2'b01;
        in_data[0 +: DW] = beat(0, 9);
        #1;
        chk("max_beats_left", dut.beats_left, 32'h0800_0000);
        chk("max_state", dut.state, DATA);
        @(negedge clk);
        in_data_valid = '0;
        #1;
        chk("max_beats_left_dec", dut.beats_left, 32'h07FF_FFFF);
        rst = 1'b0;
        #1;
        chk("max_rst_state", dut.state, IDLE);
        @(negedge clk);
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
